// File: rtl/switch_dispatch_arbiter.sv
// Captures the switch word on each debounced button rising edge into a small FIFO and hands
// one word per grant to requesting cores. Define SWDISP_ROUND_ROBIN_EN for round-robin, else fixed priority.

module switch_dispatch_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic win,
    output logic gnt
);
    // Registered one-cycle grant pulse for a single requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gnt <= 1'b0;
        else        gnt <= win;
    end
endmodule

module switch_dispatch_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [31:0]                   Switches,
    input  logic                          Button,
    input  logic [NUM_REQ-1:0]            Req,
    output logic [NUM_REQ-1:0]            Gnt,
    output logic [31:0]                   Data,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overflow,
    input  logic                          Clear_Overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               last_button;
    logic               capture, full, push, pop;
    logic [IW-1:0]      sel;
    logic [NUM_REQ-1:0] win;

    assign capture = Button && !last_button;
    assign full    = (Count == FULL_CNT);
    assign push    = capture && !full;
    // Pop looks at the pre-push count, so a word landing in an empty FIFO waits a cycle.
    assign pop     = (Count != '0) && (|Req);

`ifdef SWDISP_ROUND_ROBIN_EN
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        sel   = last_gnt;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_gnt) + i) % NUM_REQ);
            if (!found && Req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)  last_gnt <= IW'(NUM_REQ - 1);
        else if (pop)  last_gnt <= sel;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req[i]) sel = IW'(i);
        end
    end
`endif

    always_comb begin
        win = '0;
        if (pop) win[sel] = 1'b1;
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        switch_dispatch_lane u_lane (
            .clk   (HCLK),
            .rst_n (HRESETn),
            .win   (win[g]),
            .gnt   (Gnt[g])
        );
    end

    // Storage needs no reset: Count and the pointers define which entries are live.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= Switches;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Count       <= '0;
            Data        <= '0;
            Overflow    <= 1'b0;
            last_button <= 1'b0;
        end else begin
            last_button <= Button;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                Data   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
            if (capture && full)     Overflow <= 1'b1;
            else if (Clear_Overflow) Overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_switch_dispatch_arbiter.sv
// Self-checking bench for switch_dispatch_arbiter: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.

module tb_switch_dispatch_arbiter;
    localparam int NR = 4;
    localparam int DEPTH = 4;

    logic        HCLK, HRESETn;
    logic [31:0] Switches;
    logic        Button;
    logic [NR-1:0] Req;
    logic [NR-1:0] Gnt;
    logic [31:0] Data;
    logic [2:0]  Count;
    logic        Overflow;
    logic        Clear_Overflow;

    switch_dispatch_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .Switches(Switches), .Button(Button),
        .Req(Req), .Gnt(Gnt), .Data(Data), .Count(Count), .Overflow(Overflow),
        .Clear_Overflow(Clear_Overflow)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the FIFO is simply a queue of words.
    logic [31:0]   mq[$];
    bit            m_lb, m_ovf;
    logic [NR-1:0] m_gnt;
    logic [31:0]   m_data;
    int            m_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lb = 0; m_ovf = 0; m_gnt = '0; m_data = '0; m_last = NR - 1;
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit b, input logic [31:0] sw, input logic [NR-1:0] rq, input bit clr);
        int pre, s;
        bit cap;
        Button = b; Switches = sw; Req = rq; Clear_Overflow = clr;
        pre = mq.size();
        cap = b && !m_lb;
        m_lb = b;
        m_gnt = '0;
        if (pre > 0 && rq != '0) begin
            s = 0;
`ifdef SWDISP_ROUND_ROBIN_EN
            for (int i = 1; i <= NR; i++) begin
                int k;
                k = (m_last + i) % NR;
                if (rq[k]) begin s = k; break; end
            end
            m_last = s;
`else
            for (int i = NR - 1; i >= 0; i--) if (rq[i]) s = i;
`endif
            m_gnt[s] = 1'b1;
            m_data = mq.pop_front();
        end
        if (cap && pre == DEPTH) m_ovf = 1;
        else begin
            if (cap) mq.push_back(sw);
            if (clr) m_ovf = 0;
        end
        @(posedge HCLK); #1;
        chk("model_gnt",   32'(Gnt), 32'(m_gnt));
        chk("model_data",  Data, m_data);
        chk("model_count", 32'(Count), 32'(mq.size()));
        chk("model_ovf",   32'(Overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        HRESETn = 1'b0; Button = 0; Req = '0; Clear_Overflow = 0; Switches = '0;
        @(posedge HCLK); @(posedge HCLK); #1;
        chk("rst_gnt", 32'(Gnt), 0);
        chk("rst_data", Data, 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_ovf", 32'(Overflow), 0);
        HRESETn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          b;
        logic [31:0] sw;
        logic [3:0]  rq;
        bit          clr;
        logic [3:0]  gnt;
        logic [31:0] data;
        logic [2:0]  cnt;
        bit          ovf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{b:0, sw:32'h0,         rq:4'b0000, clr:0, gnt:4'b0000, data:32'h0,         cnt:3'd0, ovf:0};
        tbl[1] = '{b:1, sw:32'hA5A5_0001, rq:4'b0000, clr:0, gnt:4'b0000, data:32'h0,         cnt:3'd1, ovf:0};
        tbl[2] = '{b:0, sw:32'h0,         rq:4'b0100, clr:0, gnt:4'b0100, data:32'hA5A5_0001, cnt:3'd0, ovf:0};
        tbl[3] = '{b:0, sw:32'h0,         rq:4'b0000, clr:0, gnt:4'b0000, data:32'hA5A5_0001, cnt:3'd0, ovf:0};
        tbl[4] = '{b:1, sw:32'h11,        rq:4'b0001, clr:0, gnt:4'b0000, data:32'hA5A5_0001, cnt:3'd1, ovf:0};
        tbl[5] = '{b:1, sw:32'h0,         rq:4'b0001, clr:0, gnt:4'b0001, data:32'h11,        cnt:3'd0, ovf:0};
        tbl[6] = '{b:0, sw:32'h0,         rq:4'b0001, clr:0, gnt:4'b0000, data:32'h11,        cnt:3'd0, ovf:0};

        HRESETn = 1'b0;
        model_reset();
        do_reset();

        // Directed vectors: capture, grant latency, empty-FIFO bypass rule.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].b, tbl[i].sw, tbl[i].rq, tbl[i].clr);
            chk($sformatf("vec%0d_gnt", i),   32'(Gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_data", i),  Data, tbl[i].data);
            chk($sformatf("vec%0d_count", i), 32'(Count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(Overflow), 32'(tbl[i].ovf));
        end

        // Fairness with all requesters active.
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            step(1, 32'(w), '0, 0);
            step(0, 0, '0, 0);
        end
        chk("fair_loaded", 32'(Count), 4);
        for (int w = 1; w <= 4; w++) begin
            step(0, 0, 4'b1111, 0);
`ifdef SWDISP_ROUND_ROBIN_EN
            chk("fair_gnt", 32'(Gnt), 32'(1 << (w - 1)));
`else
            chk("fair_gnt", 32'(Gnt), 32'h1);
`endif
            chk("fair_data", Data, 32'(w));
            chk("fair_count", 32'(Count), 32'(4 - w));
        end
        step(0, 0, 4'b1111, 0);
        chk("fair_empty_gnt", 32'(Gnt), 0);

        // Overflow: fifth press dropped, clear loses to a same-cycle set.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            step(1, 32'h100 + 32'(w), '0, 0);
            step(0, 0, '0, 0);
        end
        chk("ovf_count", 32'(Count), 4);
        chk("ovf_set", 32'(Overflow), 1);
        step(1, 32'h106, '0, 1);
        chk("ovf_set_beats_clr", 32'(Overflow), 1);
        step(0, 0, '0, 1);
        chk("ovf_clr", 32'(Overflow), 0);
        for (int w = 1; w <= 4; w++) begin
            step(0, 0, 4'b0001, 0);
            chk("ovf_drain_data", Data, 32'h100 + 32'(w));
        end
        step(0, 0, 4'b0001, 0);
        chk("ovf_no_fifth", 32'(Gnt), 0);

        // Simultaneous push/pop with pointer wrap.
        do_reset();
        step(1, 32'h200, '0, 0); step(0, 0, '0, 0);
        step(1, 32'h201, '0, 0); step(0, 0, '0, 0);
        for (int j = 0; j < 5; j++) begin
            step(1, 32'h210 + 32'(j), 4'b0001, 0);
            chk("pp_count", 32'(Count), 2);
            chk("pp_gnt", 32'(Gnt), 1);
            step(0, 0, '0, 0);
        end
        step(0, 0, 4'b0010, 0);
        chk("pp_tail0", Data, 32'h213);
        step(0, 0, 4'b0010, 0);
        chk("pp_tail1", Data, 32'h214);

        // Reset mid-operation drops the pending grant and all stored words.
        do_reset();
        for (int w = 0; w < 3; w++) begin
            step(1, 32'h300 + 32'(w), '0, 0);
            step(0, 0, '0, 0);
        end
        step(0, 0, 4'b1111, 0);
        chk("mid_gnt_before", 32'(Gnt), 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_gnt_async", 32'(Gnt), 0);
        chk("mid_count_async", 32'(Count), 0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 4'b1111, 0);
            chk("mid_no_stale", 32'(Gnt), 0);
        end

        // Random traffic against the reference model.
        for (int j = 0; j < 1500; j++) begin
            logic [NR-1:0] rq;
            rq = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(0, 15)) : '0;
            step(bit'($urandom_range(0, 1)), $urandom, rq, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_dispatch_arbiter.md
# switch_dispatch_arbiter

Shares the single board switch/button input among NUM_REQ processor cores of the MIMD array. Each rising edge of the debounced button captures the 32-bit switch word into a small FIFO. Words are handed out one per grant to requesting cores under round-robin arbitration, so every value entered by the user is delivered to exactly one core. It sits between the debounced button/switch inputs and the per-core input slaves.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting cores (2..8)
- FIFO_DEPTH, 4, entries of switch-word storage (power of 2, ≥2)

Ports:
- Clock and reset: one clock, `HCLK`; reset `HRESETn`, asynchronous, active-low.
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- Switches  input  32  switch word, sampled on the capture cycle
- Button  input  1  debounced button level, already synchronous to HCLK
- Req  input  NUM_REQ  per-core level request for one word
- Gnt  output  NUM_REQ  one-hot, one-cycle grant pulse; reset 0
- Data  output  32  word delivered with Gnt; reset 0; holds last granted word otherwise
- Count  output  $clog2(FIFO_DEPTH)+1  words currently stored; reset 0
- Overflow  output  1  sticky: a capture was dropped because FIFO was full; reset 0
- Clear_Overflow  input  1  synchronous clear of Overflow

## Operation
- Edge detect: internal last_button register (reset 0). capture = Button && !last_button.
- Push: on capture with Count < FIFO_DEPTH, write Switches at the write pointer, advance it, Count+1.
- Full: on capture with Count == FIFO_DEPTH, the word is discarded, storage is unchanged, and Overflow is set.
  - Set has priority over Clear_Overflow in the same cycle.
- Arbitration runs each cycle when Count > 0 and |Req.
  - Select one requester and pop the head word.
  - Next cycle: Gnt[sel]=1, Data=popped word.
- Pop uses the pre-push Count. A word pushed into an empty FIFO is not grantable until the following cycle.
- Simultaneous push and pop: both occur, Count unchanged, pointers advance independently.
- Pointers wrap modulo FIFO_DEPTH. Count spans 0..FIFO_DEPTH inclusive.
- A requester keeping Req high after Gnt remains eligible. It receives further words subject to the round-robin order.
- Req deasserted in the arbitration cycle is never granted. No grant is ever issued without a pop.
- Reset at any time clears the FIFO, pointers, Count, Overflow, Gnt, Data, last_button, and the arbitration state. A pending grant is lost.

## Timing
- Capture: edge seen in cycle t; Count reflects it from t+1; the word is grantable from t+1.
- Grant latency: Req high at edge k with Count>0 → Gnt pulse during cycle k+1 (registered outputs).
- Throughput: one grant per cycle, regardless of which requester.
- Count decrements in the same cycle Gnt is visible.
- Gnt is never asserted for two bits simultaneously.

## Configuration
- Macro `SWDISP_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - The last-granted index is stored; reset value NUM_REQ-1, so index 0 has first priority.
  - Search starts at last+1 and wraps. The pointer updates only on a grant.
- Undefined: fixed priority; the lowest asserted Req index always wins. No pointer state is stored.

## Test plan
- Reset/idle: hold HRESETn low, then release with Req=0 → Gnt=0, Data=0, Count=0, Overflow=0 throughout.
- Capture and grant:
  - Switches=32'hA5A5_0001, pulse Button; later Req=4'b0100.
  - Required: Count=1, then Gnt=4'b0100 and Data=32'hA5A5_0001 one cycle after Req sampled; Count=0 afterwards.
- Fairness (RR_EN defined): load 4 words 1,2,3,4, then hold Req=4'b1111 → Gnt sequence 0001,0010,0100,1000 carrying 1,2,3,4 on consecutive cycles.
  - Without the macro: four grants to 0001.
- Overflow: 5 button presses with FIFO_DEPTH=4 → Count=4, Overflow=1, 5th word never delivered.
  - Clear_Overflow on the same cycle as a 6th press → Overflow stays 1.
- Simultaneous push/pop: Count=2, Req=0001, capture in the same cycle → Count stays 2, FIFO order preserved across pointer wrap (≥6 words total).
- Reset mid-operation: Count=3 with Req active, assert HRESETn low for 1 cycle → Gnt drops immediately, Count=0, no stale words granted after release.
